nvm_ctrl: RTL and testbench
===========================

NVM_CTRL -- requirements
Module: nvm_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 8, NVM word-address width; DATA_WIDTH, default 32, data width; PROG_CYCLES, default 4, program delay in cycles (at least 1); UNLOCK_KEY, default 32'hA5C3_5A3C, unlock value.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 Port clk, input, width 1: rising-edge clock.
REQ-004 Port rst, input, width 1: asynchronous, active-high reset.
REQ-005 Port cmd_valid, input, width 1: command present.
REQ-006 Port cmd_op, input, width 2: 00 read, 01 program, 10 unlock, 11 reserved.
REQ-007 Port cmd_addr, input, width ADDR_WIDTH: word address.
REQ-008 Port cmd_wdata, input, width DATA_WIDTH: program data, or the key for unlock.
REQ-009 Port cmd_ready, output, width 1: controller can accept a command.
REQ-010 Port rsp_valid, output, width 1: one-cycle completion pulse.
REQ-011 Port rsp_rdata, output, width DATA_WIDTH: read data, or programmed data read back.
REQ-012 Port rsp_err, output, width 1: error flag, qualified by rsp_valid.
REQ-013 Port busy, output, width 1: a command is in flight.
REQ-014 Port unlocked, output, width 1: unlock state.
REQ-015 Ports mem_we (width 1), mem_addr (width ADDR_WIDTH) and mem_wd (width DATA_WIDTH), outputs: drive the NVM array.
REQ-016 Port mem_rd, input, width DATA_WIDTH: combinational read data from the NVM array.

Function
REQ-017 The FSM states SHALL be IDLE, RD, PWAIT, WR, VFY and RSP.
REQ-018 cmd_ready SHALL equal (state==IDLE), and busy SHALL equal !cmd_ready.
REQ-019 A command SHALL be accepted on a rising edge with cmd_valid && cmd_ready; at acceptance, cmd_op, cmd_addr and cmd_wdata SHALL be latched.
REQ-020 mem_addr SHALL always drive the latched address; mem_wd SHALL always drive the latched data.
REQ-021 Read: IDLE->RD; in RD, rsp_rdata <= mem_rd; RD->RSP.
REQ-022 Unlock with a matching key SHALL set unlocked; a mismatching key SHALL clear unlocked and give rsp_err=1; both cases SHALL go IDLE->RSP.
REQ-023 Program while locked, or reserved op 11, SHALL go IDLE->RSP with rsp_err=1 and SHALL never assert mem_we.
REQ-024 Program while unlocked SHALL go IDLE->PWAIT; a down-counter loaded with PROG_CYCLES-1 SHALL decrement each cycle; at 0 the FSM SHALL go to WR.
REQ-025 In WR, mem_we SHALL be 1 for exactly one cycle; unlocked SHALL clear (single-shot unlock); WR->VFY.
REQ-026 In VFY, rsp_rdata <= mem_rd; rsp_err <= (mem_rd != latched data); VFY->RSP.
REQ-027 In RSP, rsp_valid SHALL be 1 for exactly one cycle; RSP->IDLE.
REQ-028 rsp_rdata and rsp_err SHALL hold their values until the next response.
REQ-029 Latency, acceptance edge to the rsp_valid cycle: read 2 cycles; unlock/error 1 cycle; program PROG_CYCLES+3 cycles.
REQ-030 cmd_valid while busy SHALL be ignored: no acceptance, and no change to the latched fields.
REQ-031 A back-to-back command SHALL be acceptable on the edge that ends RSP plus one, i.e. in the first IDLE cycle.
REQ-032 A read of a word just programmed SHALL return the new data.
REQ-033 A read SHALL NOT change unlocked.
REQ-034 Addresses SHALL be used as given; the all-ones address is valid and SHALL NOT wrap or fault.

Reset
REQ-035 rst=1 SHALL immediately force state=IDLE, counter=0, unlocked=0, mem_we=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, latched fields=0, cmd_ready=1 and busy=0.
REQ-036 rst during PWAIT or WR SHALL abort the program without a write, or truncate the write in progress, and no rsp_valid SHALL follow.
REQ-037 After rst deasserts, the first edge SHALL be able to accept a command.

Verification
REQ-038 Locked program at addr 0x10, data 0x1234 -> rsp_valid 1 cycle after acceptance, rsp_err=1, mem_we never high, word 0x10 unchanged.
REQ-039 Unlock 0xA5C3_5A3C, then program 0x10 = 0xDEADBEEF -> mem_we high exactly 1 cycle at acceptance+PROG_CYCLES+1, rsp_valid at +7 with PROG_CYCLES=4, rsp_rdata=0xDEADBEEF, rsp_err=0, unlocked=0.
REQ-040 Read 0x10 after REQ-039 -> rsp_valid 2 cycles after acceptance, rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-041 Unlock with key 0x0 -> rsp_err=1, unlocked=0; a following program SHALL be rejected.
REQ-042 Unlock, start program 0xFF = 0x55, assert rst in the 2nd PWAIT cycle -> outputs reset immediately, word 0xFF unchanged, unlocked=0, no rsp_valid.
REQ-043 cmd_valid held high continuously with alternating ops -> exactly one acceptance per IDLE cycle, latched fields stable while busy, op 11 -> rsp_err=1.

Source files
------------

// File: rtl/nvm_ctrl.sv
// NVM command controller: read, keyed single-shot unlock, and timed program with verify.
// The NVM array is external; the controller drives its address, write data and write enable.
module nvm_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned PROG_CYCLES = 4,
  parameter logic [DATA_WIDTH-1:0] UNLOCK_KEY = DATA_WIDTH'(32'hA5C3_5A3C)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  cmd_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  unlocked,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wd,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  localparam int unsigned CNT_W = (PROG_CYCLES > 1) ? $clog2(PROG_CYCLES) : 1;

  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_PG = 2'b01;
  localparam logic [1:0] OP_UL = 2'b10;

  typedef enum logic [2:0] {IDLE, RD, PWAIT, WR, VFY, RSP} state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [1:0]            lat_op;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_data;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign mem_addr  = lat_addr;
  assign mem_wd    = lat_data;

  // rsp_valid and mem_we are set on the edge entering RSP/WR so they coincide with those states
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_op    <= '0;
      lat_addr  <= '0;
      lat_data  <= '0;
      unlocked  <= 1'b0;
      mem_we    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      mem_we    <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            lat_op   <= cmd_op;
            lat_addr <= cmd_addr;
            lat_data <= cmd_wdata;
            case (cmd_op)
              OP_RD: state <= RD;
              OP_UL: begin
                unlocked  <= (cmd_wdata == UNLOCK_KEY);
                rsp_err   <= (cmd_wdata != UNLOCK_KEY);
                rsp_valid <= 1'b1;
                state     <= RSP;
              end
              OP_PG: begin
                if (unlocked) begin
                  cnt   <= CNT_W'(PROG_CYCLES - 1);
                  state <= PWAIT;
                end else begin
                  rsp_err   <= 1'b1;
                  rsp_valid <= 1'b1;
                  state     <= RSP;
                end
              end
              default: begin
                rsp_err   <= 1'b1;
                rsp_valid <= 1'b1;
                state     <= RSP;
              end
            endcase
          end
        end
        PWAIT: begin
          if (cnt == '0) begin
            mem_we <= 1'b1;
            state  <= WR;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        WR: begin
          unlocked <= 1'b0;
          state    <= VFY;
        end
        // Read capture and program verify share the sampling path; only verify can flag an error
        RD, VFY: begin
          rsp_rdata <= mem_rd;
          rsp_err   <= (lat_op == OP_PG) && (mem_rd != lat_data);
          rsp_valid <= 1'b1;
          state     <= RSP;
        end
        RSP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nvm_ctrl.sv
// Randomized scoreboard bench for nvm_ctrl with an external NVM array model
// and a command-level reference model of lock state, array contents and latency.
module tb_nvm_ctrl;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int P  = 4;
  localparam logic [DW-1:0] KEY = 32'hA5C3_5A3C;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          unl;
    int            lat;
    int            acc;
    bit            we;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          cmd_ready, rsp_valid, rsp_err, busy, unlocked, mem_we;
  logic [DW-1:0] rsp_rdata, mem_wd, mem_rd;
  logic [AW-1:0] mem_addr;

  nvm_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PROG_CYCLES(P), .UNLOCK_KEY(KEY)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy), .unlocked(unlocked), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // NVM array the DUT drives, and the reference copy the model updates per command
  logic [DW-1:0] nvm     [256];
  logic [DW-1:0] ref_mem [256];
  always @(posedge clk) if (mem_we) nvm[mem_addr] <= mem_wd;
  assign mem_rd = nvm[mem_addr];

  exp_t          sb[$];
  int            vectors = 0;
  int            miscompares = 0;
  bit            ref_unl = 0;
  logic [DW-1:0] last_rdata = '0;
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] cur_data = '0;
  int            we_seen = 0;
  exp_t          e;

  // Monitor: latched-field stability, write-pulse timing and response scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      vectors++;
      if (busy !== !cmd_ready || (busy && (mem_addr !== cur_addr || mem_wd !== cur_data))) begin
        miscompares++;
        $display("FAIL latch: busy=%b ready=%b addr=%h data=%h, required addr=%h data=%h",
                 busy, cmd_ready, mem_addr, mem_wd, cur_addr, cur_data);
      end
      if (mem_we) begin
        we_seen++;
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL we_pulse: mem_we high with no command pending");
        end else if (!sb[0].we || cyc - sb[0].acc != P + 1) begin
          miscompares++;
          $display("FAIL we_pulse: at +%0d (write expected=%0b), required at +%0d",
                   cyc - sb[0].acc, sb[0].we, P + 1);
        end
      end
      if (rsp_valid) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL rsp: unexpected rsp_valid rdata=%h err=%b", rsp_rdata, rsp_err);
        end else begin
          e = sb.pop_front();
          if (rsp_rdata !== e.rdata || rsp_err !== e.err || unlocked !== e.unl ||
              cyc - e.acc != e.lat || we_seen != int'(e.we)) begin
            miscompares++;
            $display("FAIL rsp: rdata=%h err=%b unl=%b lat=%0d we=%0d, required rdata=%h err=%b unl=%b lat=%0d we=%0d",
                     rsp_rdata, rsp_err, unlocked, cyc - e.acc, we_seen,
                     e.rdata, e.err, e.unl, e.lat, int'(e.we));
          end
        end
        we_seen = 0;
      end
    end
  end

  // Drive a command in the current (idle) cycle and record what the specification predicts
  task automatic send(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t x;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_wdata = d;
    x.acc = cyc; x.we = 0; x.rdata = last_rdata; x.err = 0; x.lat = 1;
    case (op)
      2'b00: begin x.rdata = ref_mem[a]; x.lat = 2; end
      2'b01: begin
        if (ref_unl) begin
          ref_mem[a] = d; x.rdata = d; x.lat = P + 3; x.we = 1; ref_unl = 0;
        end else x.err = 1;
      end
      2'b10: begin ref_unl = (d == KEY); x.err = !ref_unl; end
      default: x.err = 1;
    endcase
    x.unl = ref_unl;
    last_rdata = x.rdata;
    cur_addr = a; cur_data = d;
    sb.push_back(x);
  endtask

  // Wait for an idle cycle while throwing ignored commands at the busy controller
  task automatic wait_ready();
    int t = 0;
    forever begin
      @(negedge clk); #1;
      if (cmd_ready) break;
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_op = 2'($urandom); cmd_addr = AW'($urandom); cmd_wdata = $urandom;
      t++;
      if (t > 40) begin
        vectors++; miscompares++;
        $display("FAIL timeout: cmd_ready=%b, required 1 within 40 cycles", cmd_ready);
        break;
      end
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wait_ready();
    send(op, a, d);
  endtask

  task automatic idle_wait(input int n);
    wait_ready();
    cmd_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  logic [DW-1:0] saved_ff;
  logic [AW-1:0] ra;

  initial begin
    for (int i = 0; i < 256; i++) begin
      nvm[i] = 32'h1357_0000 ^ (i * 32'h0101_0101);
      ref_mem[i] = 32'h1357_0000 ^ (i * 32'h0101_0101);
    end
    #1;
    vectors++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 ||
        rsp_rdata !== '0 || unlocked !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wd !== '0) begin
      miscompares++;
      $display("FAIL reset_state: ready=%b busy=%b valid=%b err=%b rdata=%h unl=%b we=%b addr=%h wd=%h, required 1 0 0 0 0 0 0 0 0",
               cmd_ready, busy, rsp_valid, rsp_err, rsp_rdata, unlocked, mem_we, mem_addr, mem_wd);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Directed: locked program, unlock+program, readback, bad key, reserved op, all-ones address
    issue(2'b01, 8'h10, 32'h0000_1234);
    issue(2'b10, 8'h00, KEY);
    issue(2'b01, 8'h10, 32'hDEAD_BEEF);
    issue(2'b00, 8'h10, 32'h0);
    issue(2'b10, 8'h00, 32'h0);
    issue(2'b01, 8'h20, 32'h1);
    issue(2'b11, 8'h30, 32'h2);
    issue(2'b10, 8'h00, KEY);
    issue(2'b00, 8'hFF, 32'h0);
    issue(2'b01, 8'hFF, 32'hCAFE_F00D);
    issue(2'b00, 8'hFF, 32'h0);
    idle_wait(3);

    // Random traffic over a small address set so programs and reads collide
    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 3))
        0: ra = 8'h00;
        1: ra = 8'h10;
        2: ra = 8'hFF;
        default: ra = AW'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: issue(2'b00, ra, $urandom);
        1: issue(2'b01, ra, $urandom);
        2: issue(2'b10, ra, ($urandom_range(0, 9) < 7) ? KEY : $urandom);
        default: issue(2'b11, ra, $urandom);
      endcase
      if ($urandom_range(0, 7) == 0) idle_wait(1);
    end
    idle_wait(2);

    // Reset in the second PWAIT cycle aborts the program
    issue(2'b10, 8'h00, KEY);
    saved_ff = ref_mem[8'hFF];
    issue(2'b01, 8'hFF, 32'h0000_0055);
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst = 1'b1;
    cmd_valid = 1'b0;
    #1;
    vectors++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 ||
        rsp_rdata !== '0 || unlocked !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wd !== '0) begin
      miscompares++;
      $display("FAIL mid_reset: ready=%b busy=%b valid=%b err=%b rdata=%h unl=%b we=%b addr=%h wd=%h, required 1 0 0 0 0 0 0 0 0",
               cmd_ready, busy, rsp_valid, rsp_err, rsp_rdata, unlocked, mem_we, mem_addr, mem_wd);
    end
    sb.delete();
    we_seen = 0;
    ref_unl = 0;
    last_rdata = '0;
    ref_mem[8'hFF] = saved_ff;
    cur_addr = '0; cur_data = '0;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    send(2'b00, 8'hFF, 32'h0);
    issue(2'b01, 8'hFF, 32'h0000_0055);
    issue(2'b00, 8'hFF, 32'h0);
    idle_wait(10);

    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1, "watchdog");
  end

endmodule
